// File: rtl/alien_motion_pkg.sv
// Shared motion codes and march-state encoding for the alien, player and bullet motion blocks.
package alien_motion_pkg;

    typedef enum logic [1:0] {
        NO_MOTION = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2,
        DOWN      = 2'd3
    } motion_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RIGHT,
        ST_LEFT,
        ST_DOWN,
        ST_LANDED
    } march_state_t;

    function automatic motion_t state_motion(input march_state_t s);
        case (s)
            ST_RIGHT: state_motion = RIGHT;
            ST_LEFT:  state_motion = LEFT;
            ST_DOWN:  state_motion = DOWN;
            default:  state_motion = NO_MOTION;
        endcase
    endfunction

endpackage

// File: rtl/alien_march_ctrl_if.sv
// Bounds/alive inputs and motion outputs between the formation logic and the march controller.
interface alien_march_ctrl_if #(
    parameter int COUNT_W = 6
) ();
    logic               enable;
    logic               canLeft;
    logic               canRight;
    logic               canDown;
    logic [COUNT_W-1:0] aliveCount;
    logic [1:0]         Motion;
    logic               step;
    logic               landed;

    // master: formation bounds side; slave: march controller
    modport master (
        output enable, canLeft, canRight, canDown, aliveCount,
        input  Motion, step, landed
    );

    modport slave (
        input  enable, canLeft, canRight, canDown, aliveCount,
        output Motion, step, landed
    );
endinterface

// File: rtl/alien_step_timer.sv
// Step tick generator; the period shrinks with each destroyed alien down to a floor.
module alien_step_timer #(
    parameter int PERIOD_W    = 16,
    parameter int COUNT_W     = 6,
    parameter int MAX_ALIVE   = 40,
    parameter int BASE_PERIOD = 50000,
    parameter int MIN_PERIOD  = 2000,
    parameter int PERIOD_STEP = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [COUNT_W-1:0] aliveCount,
    output logic               tick
);
    localparam int PW = PERIOD_W + COUNT_W;

    logic [COUNT_W-1:0]  clamped;
    logic [COUNT_W-1:0]  killed;
    logic [PW-1:0]       dec;
    logic [PERIOD_W-1:0] period;
    logic [PERIOD_W-1:0] cnt;
    logic                run;

    always_comb begin
        clamped = (aliveCount > COUNT_W'(MAX_ALIVE)) ? COUNT_W'(MAX_ALIVE) : aliveCount;
        killed  = COUNT_W'(MAX_ALIVE) - clamped;
        dec     = PW'(killed) * PW'(PERIOD_STEP);
        if (dec >= PW'(BASE_PERIOD - MIN_PERIOD))
            period = PERIOD_W'(MIN_PERIOD);
        else
            period = PERIOD_W'(BASE_PERIOD) - dec[PERIOD_W-1:0];
    end

    // >= rather than == so a period that shrinks past the count ticks immediately
    assign run  = enable && (aliveCount != '0);
    assign tick = run && (cnt >= period - PERIOD_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (run)
            cnt <= cnt + PERIOD_W'(1);
    end

endmodule

// File: rtl/alien_march_ctrl.sv
// Alien formation march FSM: right/left zig-zag with multi-row descent and sticky landing.
module alien_march_ctrl
    import alien_motion_pkg::*;
#(
    parameter int DOWN_STEPS  = 2,
    parameter int PERIOD_W    = 16,
    parameter int COUNT_W     = 6,
    parameter int MAX_ALIVE   = 40,
    parameter int BASE_PERIOD = 50000,
    parameter int MIN_PERIOD  = 2000,
    parameter int PERIOD_STEP = 1000
) (
    input  logic               clk,
    input  logic               reset,
    alien_march_ctrl_if.slave  bus
);
    localparam int DC_W = (DOWN_STEPS > 1) ? $clog2(DOWN_STEPS) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DOWN_STEPS - 1);

    logic            tick;
    march_state_t    state, state_nx;
    motion_t         dir, dir_nx;
    logic [DC_W-1:0] dcnt, dcnt_nx;
    motion_t         motion_q, motion_nx;
    logic            step_q, step_nx;
    logic            landed_q, landed_nx;

    alien_step_timer #(
        .PERIOD_W    (PERIOD_W),
        .COUNT_W     (COUNT_W),
        .MAX_ALIVE   (MAX_ALIVE),
        .BASE_PERIOD (BASE_PERIOD),
        .MIN_PERIOD  (MIN_PERIOD),
        .PERIOD_STEP (PERIOD_STEP)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .enable     (bus.enable),
        .aliveCount (bus.aliveCount),
        .tick       (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            dir      <= RIGHT;
            dcnt     <= '0;
            motion_q <= NO_MOTION;
            step_q   <= 1'b0;
            landed_q <= 1'b0;
        end else begin
            state    <= state_nx;
            dir      <= dir_nx;
            dcnt     <= dcnt_nx;
            motion_q <= motion_nx;
            step_q   <= step_nx;
            landed_q <= landed_nx;
        end
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        dcnt_nx  = dcnt;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (bus.canRight)      state_nx = ST_RIGHT;
                    else if (bus.canLeft)  state_nx = ST_LEFT;
                    else if (bus.canDown) begin
                        state_nx = ST_DOWN;
                        dir_nx   = RIGHT;
                        dcnt_nx  = '0;
                    end else               state_nx = ST_LANDED;
                end
                ST_RIGHT: begin
                    if (bus.canRight)      state_nx = ST_RIGHT;
                    else if (bus.canDown) begin
                        state_nx = ST_DOWN;
                        dir_nx   = RIGHT;
                        dcnt_nx  = '0;
                    end else               state_nx = ST_LANDED;
                end
                ST_LEFT: begin
                    if (bus.canLeft)       state_nx = ST_LEFT;
                    else if (bus.canDown) begin
                        state_nx = ST_DOWN;
                        dir_nx   = LEFT;
                        dcnt_nx  = '0;
                    end else               state_nx = ST_LANDED;
                end
                ST_DOWN: begin
                    if (dcnt != DC_LAST) begin
                        if (bus.canDown)   dcnt_nx  = dcnt + DC_W'(1);
                        else               state_nx = ST_LANDED;
                    end else if (dir == RIGHT) begin
                        // reverse first, fall back to the previous heading
                        if (bus.canLeft)       state_nx = ST_LEFT;
                        else if (bus.canRight) state_nx = ST_RIGHT;
                        else                   state_nx = ST_IDLE;
                    end else begin
                        if (bus.canRight)      state_nx = ST_RIGHT;
                        else if (bus.canLeft)  state_nx = ST_LEFT;
                        else                   state_nx = ST_IDLE;
                    end
                end
                ST_LANDED: state_nx = ST_LANDED;
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // ticks keep coming in LANDED but produce no further pulses
    always_comb begin
        motion_nx = motion_q;
        step_nx   = 1'b0;
        landed_nx = landed_q;
        if (tick && state != ST_LANDED) begin
            step_nx   = 1'b1;
            motion_nx = state_motion(state_nx);
            landed_nx = (state_nx == ST_LANDED);
        end
    end

    assign bus.Motion = motion_q;
    assign bus.step   = step_q;
    assign bus.landed = landed_q;

endmodule

// File: doc/alien_march_ctrl.md
# alien_march_ctrl

Parametrised march controller for the alien formation. It generates its own step ticks, with the step period shrinking as aliens are destroyed. It drives the formation in a right/left zig-zag with a configurable multi-row descent at each edge, and flags a sticky landing when the formation can no longer descend. It sits between the formation bounds logic (canLeft/canRight/canDown, alive count) and the formation position registers, which apply Motion on each step pulse.

## Interface
Parameters:
- DOWN_STEPS, 2: consecutive down moves per edge reversal (≥1).
- PERIOD_W, 16: width of step period counter.
- COUNT_W, 6: width of aliveCount.
- MAX_ALIVE, 40: alive count at full formation.
- BASE_PERIOD, 50000: clk cycles per step at MAX_ALIVE (< 2^PERIOD_W).
- MIN_PERIOD, 2000: floor on step period (≥1).
- PERIOD_STEP, 1000: cycles removed from the period per destroyed alien.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run; low pauses the step counter (value held).
- canLeft  in  1  formation may move one step left.
- canRight  in  1  formation may move one step right.
- canDown  in  1  formation may move one row down.
- aliveCount  in  COUNT_W  aliens remaining.
- Motion  out  2  registered move code: 0 none, 1 left, 2 right, 3 down.
- step  out  1  one-cycle pulse; Motion is valid to apply in that cycle.
- landed  out  1  sticky; formation reached bottom.

## Operation
- Period: killed = MAX_ALIVE − min(aliveCount, MAX_ALIVE). Compute killed×PERIOD_STEP at PERIOD_W+COUNT_W bits.
  - If killed×PERIOD_STEP ≥ BASE_PERIOD − MIN_PERIOD: period = MIN_PERIOD.
  - Otherwise: period = BASE_PERIOD − killed×PERIOD_STEP.
  - The period is evaluated combinationally every cycle.
- Counter: increments on each cycle with enable=1 and aliveCount≠0. A tick occurs when the counter ≥ period−1; on a tick the counter clears to 0.
  - A shrinking period mid-count therefore ticks on the next enabled cycle.
  - With aliveCount=0 the counter is frozen: no ticks, state held.
- States: IDLE(Motion 0), RIGHT(2), LEFT(1), DOWN(3), LANDED(0). Auxiliary registers:
  - dir: last horizontal direction, reset RIGHT.
  - downCnt: 0..DOWN_STEPS−1.
- Transitions, evaluated on ticks only:
  - IDLE: canRight→RIGHT; else canLeft→LEFT; else canDown→DOWN (dir=RIGHT, downCnt=0); else LANDED.
  - RIGHT: canRight→stay; else canDown→DOWN (dir=RIGHT, downCnt=0); else LANDED.
  - LEFT: mirror of RIGHT, with dir=LEFT.
  - DOWN, downCnt<DOWN_STEPS−1: canDown→stay, downCnt+1; else LANDED.
  - DOWN, downCnt=DOWN_STEPS−1: go opposite of dir if allowed; else same as dir if allowed; else IDLE.
  - LANDED: absorbing until reset; landed=1.
- Each tick emits exactly one step pulse, including when the state is unchanged. It also emits one when entering LANDED (Motion=0 on that pulse), and none afterwards.
- Simultaneous events:
  - canLeft and canRight both 1 in IDLE: RIGHT wins.
  - enable falling in the tick cycle: no tick (enable is required).

## Timing
- Reset (asynchronous, effective without a clock edge) sets: counter 0, state IDLE, dir RIGHT, downCnt 0, Motion 0, step 0, landed 0.
- Tick edge: state, Motion, landed and step all update on the same clk edge. Motion/step are registered, with zero combinational path from inputs.
- With enable held high from reset release and a constant period P, step is high in the cycles following enabled edges P, 2P, 3P…
- Pause: every disabled cycle delays the next step by exactly one cycle.
- Reset mid-operation discards the counter and downCnt; the march restarts from IDLE.

## Structure
- Package alien_motion_pkg:
  - Motion codes NO_MOTION=0, LEFT=1, RIGHT=2, DOWN=3.
  - March state enum (5 states).
  - Shared with the player and bullet motion blocks.
- Sub-module alien_step_timer: period computation, counter, tick output (ports clk, reset, enable, aliveCount, tick).
- The top level holds the FSM, dir, downCnt and output registers.

## Test plan
All scenarios use BASE_PERIOD=10, MIN_PERIOD=4, PERIOD_STEP=2, MAX_ALIVE=4, DOWN_STEPS=2.
- Reset release, enable=1, aliveCount=4, canRight=1 → step pulses 10 cycles apart with Motion=2, landed=0.
- In RIGHT, drop canRight with canDown=1, canLeft=1 → next two steps Motion=3, 3, then 1; dir mirrors for the left edge.
- aliveCount 4→2 mid-count → period 6 cycles. aliveCount=1 → 4 (MIN_PERIOD clamp). aliveCount=0 → no further steps, Motion held.
- In RIGHT, canRight=0, canDown=0 → step with Motion=0 and landed=1. No further steps, even with inputs toggled, until reset.
- enable low for 7 cycles mid-period → that step arrives exactly 7 cycles late; the following step is 10 cycles after it.
- Assert reset asynchronously in DOWN (downCnt=0) → Motion=0, step=0, landed=0 before the next clk edge. After release the first step is Motion=2 (canRight=1) at cycle 10.
